ds1620_responder: RTL and testbench

- Synthesizable device-side model of the DS1620 3-wire thermometer.
- It is the responder to the DS1620 host interface: it decodes RST/CLK/DQ sessions, executes commands, and returns temperature and register data.
- It runs conversions from a supplied temperature value and drives the thermostat outputs.
- Used as a bench/FPGA stand-in so the host interface and keyscanning display path run without the physical part.

---
 rtl/ds1620_responder.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_ds1620_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ds1620_responder.sv
// ds1620_responder
//
// Device-side stand-in for a DS1620 3-wire thermometer. It decodes host
// RST/CLK/DQ sessions, runs conversions from a supplied temperature value,
// returns TEMP/TH/TL/CFG data and drives the thermostat outputs. This lets the
// host interface and display path run without the physical part.
//
// Ports
//   CLK_IN       system clock
//   CLR          synchronous reset, active-high, overrides everything
//   RST_IN       host session enable (high = transfer active), async
//   SCLK_IN      host serial clock, async to CLK_IN
//   DQ_IN        host serial data, async
//   TEMP_IN[8:0] temperature presented to the converter (0.5 C/LSB, signed)
//   DQ_OUT       serial data to host (LSB first, changes on SCLK fall)
//   DQ_OE        high while the responder drives DQ
//   TEMP[8:0]    last converted temperature
//   CONV_ACTIVE  conversion engine running
//   THIGH        TEMP >= TH (signed)
//   TLOW         TEMP <= TL (signed)
//
// FSM states
//   state  | meaning
//   IDLE   | no session; waits for synchronised RST_IN high
//   CMD    | shifting in the 8-bit command on SCLK rises
//   RX     | shifting in write data; commits on the last bit
//   TX     | driving read data on SCLK falls, counting host samples on rises
//   DONE   | session finished; SCLK ignored until RST_IN drops

module ds1620_responder #(
    parameter int unsigned CONV_CYCLES = 1000,
    parameter logic [8:0]  TH_INIT     = 9'h050,
    parameter logic [8:0]  TL_INIT     = 9'h028
) (
    input  logic       CLK_IN,
    input  logic       CLR,
    input  logic       RST_IN,
    input  logic       SCLK_IN,
    input  logic       DQ_IN,
    input  logic [8:0] TEMP_IN,
    output logic       DQ_OUT,
    output logic       DQ_OE,
    output logic [8:0] TEMP,
    output logic       CONV_ACTIVE,
    output logic       THIGH,
    output logic       TLOW
);

    localparam int unsigned CW = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CONV_CYCLES - 1);

    localparam logic [7:0] OP_RD_TEMP = 8'hAA;
    localparam logic [7:0] OP_RD_TH   = 8'hA1;
    localparam logic [7:0] OP_RD_TL   = 8'hA2;
    localparam logic [7:0] OP_RD_CFG  = 8'hAC;
    localparam logic [7:0] OP_WR_TH   = 8'h01;
    localparam logic [7:0] OP_WR_TL   = 8'h02;
    localparam logic [7:0] OP_WR_CFG  = 8'h0C;
    localparam logic [7:0] OP_START   = 8'hEE;
    localparam logic [7:0] OP_STOP    = 8'h22;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RX,
        S_TX,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        W_TH,
        W_TL,
        W_CFG
    } wsel_t;

    // synchronisers; sclk carries one extra stage for edge detection
    logic [1:0]    rst_sync_q, rst_sync_d;
    logic [2:0]    sclk_sync_q, sclk_sync_d;
    logic [1:0]    dq_sync_q, dq_sync_d;

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    len_q, len_d;
    logic [6:0]    cmd_sh_q, cmd_sh_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [8:0]    tx_sh_q, tx_sh_d;
    wsel_t         wsel_q, wsel_d;
    logic          dq_out_q, dq_out_d;
    logic          dq_oe_q, dq_oe_d;

    logic [8:0]    th_q, th_d;
    logic [8:0]    tl_q, tl_d;
    logic [1:0]    cfg_q, cfg_d;
    logic          done_q, done_d;
    logic          thf_q, thf_d;
    logic          tlf_q, tlf_d;

    logic [8:0]    temp_q, temp_d;
    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          rst_s;
    logic          dq_s;
    logic          sclk_rise;
    logic          sclk_fall;
    logic [7:0]    cmd_byte;
    logic [8:0]    rx_word;
    logic [8:0]    wr_val;
    logic          start_conv;
    logic          stop_conv;

    assign rst_s     = rst_sync_q[1];
    assign dq_s      = dq_sync_q[1];
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

    always_comb begin
        rst_sync_d  = {rst_sync_q[0], RST_IN};
        sclk_sync_d = {sclk_sync_q[1:0], SCLK_IN};
        dq_sync_d   = {dq_sync_q[0], DQ_IN};

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        cmd_sh_d   = cmd_sh_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        wsel_d     = wsel_q;
        dq_out_d   = dq_out_q;
        dq_oe_d    = dq_oe_q;

        th_d       = th_q;
        tl_d       = tl_q;
        cfg_d      = cfg_q;
        done_d     = done_q;
        thf_d      = thf_q;
        tlf_d      = tlf_q;

        temp_d     = temp_q;
        active_d   = active_q;
        cnt_d      = cnt_q;

        start_conv = 1'b0;
        stop_conv  = 1'b0;
        cmd_byte   = {dq_s, cmd_sh_q};
        rx_word    = {dq_s, rx_sh_q};
        wr_val     = '0;

        if (!rst_s) begin
            // session abort: a partially received write is simply never committed
            state_d   = S_IDLE;
            dq_oe_d   = 1'b0;
            dq_out_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_CMD;
                    bit_cnt_d = '0;
                end

                S_CMD: begin
                    if (sclk_rise) begin
                        cmd_sh_d  = cmd_byte[7:1];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            state_d   = S_DONE;
                            // read data is captured here so a conversion landing
                            // mid-read cannot tear the word
                            case (cmd_byte)
                                OP_RD_TEMP: begin
                                    tx_sh_d = temp_q;
                                    len_d   = 4'd9;
                                    state_d = S_TX;
                                end
                                OP_RD_TH: begin
                                    tx_sh_d = th_q;
                                    len_d   = 4'd9;
                                    state_d = S_TX;
                                end
                                OP_RD_TL: begin
                                    tx_sh_d = tl_q;
                                    len_d   = 4'd9;
                                    state_d = S_TX;
                                end
                                OP_RD_CFG: begin
                                    tx_sh_d = {1'b0, done_q, thf_q, tlf_q, 1'b0, 2'b10, cfg_q};
                                    len_d   = 4'd8;
                                    state_d = S_TX;
                                end
                                OP_WR_TH: begin
                                    wsel_d  = W_TH;
                                    len_d   = 4'd9;
                                    state_d = S_RX;
                                end
                                OP_WR_TL: begin
                                    wsel_d  = W_TL;
                                    len_d   = 4'd9;
                                    state_d = S_RX;
                                end
                                OP_WR_CFG: begin
                                    wsel_d  = W_CFG;
                                    len_d   = 4'd8;
                                    state_d = S_RX;
                                end
                                OP_START: start_conv = 1'b1;
                                OP_STOP:  stop_conv  = 1'b1;
                                default:  ;
                            endcase
                        end
                    end
                end

                S_RX: begin
                    if (sclk_rise) begin
                        rx_sh_d   = rx_word[8:1];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == len_q - 4'd1) begin
                            // an 8-bit word has only shifted into the upper 8 slots
                            wr_val  = (len_q == 4'd9) ? rx_word : {1'b0, rx_word[8:1]};
                            state_d = S_DONE;
                            case (wsel_q)
                                W_TH: th_d = wr_val;
                                W_TL: tl_d = wr_val;
                                default: begin
                                    cfg_d = wr_val[1:0];
                                    if (!wr_val[6]) thf_d = 1'b0;
                                    if (!wr_val[5]) tlf_d = 1'b0;
                                end
                            endcase
                        end
                    end
                end

                S_TX: begin
                    if (sclk_fall) begin
                        dq_oe_d  = 1'b1;
                        dq_out_d = tx_sh_q[0];
                        tx_sh_d  = {1'b0, tx_sh_q[8:1]};
                    end else if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == len_q - 4'd1) begin
                            dq_oe_d  = 1'b0;
                            dq_out_d = 1'b0;
                            state_d  = S_DONE;
                        end
                    end
                end

                S_DONE: ;

                default: state_d = S_IDLE;
            endcase
        end

        // conversion engine; flag compares use TH/TL as they were before any
        // write landing in this same cycle, and set after a CFG-write clear
        if (active_q) begin
            if (cnt_q == '0) begin
                temp_d = TEMP_IN;
                done_d = 1'b1;
                if ($signed(TEMP_IN) >= $signed(th_q)) thf_d = 1'b1;
                if ($signed(TEMP_IN) <= $signed(tl_q)) tlf_d = 1'b1;
                if (cfg_q[0]) active_d = 1'b0;
                else          cnt_d    = CNT_LOAD;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        if (start_conv && !active_q) begin
            active_d = 1'b1;
            cnt_d    = CNT_LOAD;
            done_d   = 1'b0;
        end

        if (stop_conv) begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (CLR) begin
            rst_sync_q  <= '0;
            sclk_sync_q <= '0;
            dq_sync_q   <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            len_q       <= '0;
            cmd_sh_q    <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            wsel_q      <= W_TH;
            dq_out_q    <= 1'b0;
            dq_oe_q     <= 1'b0;
            th_q        <= TH_INIT;
            tl_q        <= TL_INIT;
            cfg_q       <= '0;
            done_q      <= 1'b0;
            thf_q       <= 1'b0;
            tlf_q       <= 1'b0;
            temp_q      <= '0;
            active_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            sclk_sync_q <= sclk_sync_d;
            dq_sync_q   <= dq_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            cmd_sh_q    <= cmd_sh_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            wsel_q      <= wsel_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            th_q        <= th_d;
            tl_q        <= tl_d;
            cfg_q       <= cfg_d;
            done_q      <= done_d;
            thf_q       <= thf_d;
            tlf_q       <= tlf_d;
            temp_q      <= temp_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
        end
    end

    assign DQ_OUT      = dq_out_q;
    assign DQ_OE       = dq_oe_q;
    assign TEMP        = temp_q;
    assign CONV_ACTIVE = active_q;
    assign THIGH       = ($signed(temp_q) >= $signed(th_q));
    assign TLOW        = ($signed(temp_q) <= $signed(tl_q));

endmodule

// File: tb/tb_ds1620_responder.sv
// tb_ds1620_responder
//
// Directed bench for ds1620_responder acting as a 3-wire host. SCLK phases
// are 6 system clocks each. Expected values are hand-computed constants.

module tb_ds1620_responder;

    localparam int CONV = 20;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       CLR = 1'b1;
    logic       RST_IN = 1'b0;
    logic       SCLK_IN = 1'b0;
    logic       DQ_IN = 1'b0;
    logic [8:0] TEMP_IN = 9'h000;
    logic       DQ_OUT;
    logic       DQ_OE;
    logic [8:0] TEMP;
    logic       CONV_ACTIVE;
    logic       THIGH;
    logic       TLOW;

    int n_tests = 0;
    int n_fail  = 0;
    int act_cnt = 0;
    int oe_cnt  = 0;

    ds1620_responder #(
        .CONV_CYCLES(CONV),
        .TH_INIT    (9'h050),
        .TL_INIT    (9'h028)
    ) dut (
        .CLK_IN     (clk),
        .CLR        (CLR),
        .RST_IN     (RST_IN),
        .SCLK_IN    (SCLK_IN),
        .DQ_IN      (DQ_IN),
        .TEMP_IN    (TEMP_IN),
        .DQ_OUT     (DQ_OUT),
        .DQ_OE      (DQ_OE),
        .TEMP       (TEMP),
        .CONV_ACTIVE(CONV_ACTIVE),
        .THIGH      (THIGH),
        .TLOW       (TLOW)
    );

    always #5 clk = ~clk;

    // cycle counters for CONV_ACTIVE and DQ_OE, sampled mid-cycle
    always @(negedge clk) begin
        if (CONV_ACTIVE) act_cnt <= act_cnt + 1;
        if (DQ_OE)       oe_cnt  <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [8:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            SCLK_IN = 1'b0;
            DQ_IN   = v[i];
            wait_cyc(HALF);
            SCLK_IN = 1'b1;
            wait_cyc(HALF);
        end
    endtask

    task automatic read_bits(input int n, output logic [8:0] v, output int oe_miss);
        v       = '0;
        oe_miss = 0;
        for (int i = 0; i < n; i++) begin
            SCLK_IN = 1'b0;
            wait_cyc(HALF);
            if (DQ_OE !== 1'b1) oe_miss++;
            v[i] = DQ_OUT;
            SCLK_IN = 1'b1;
            wait_cyc(HALF);
        end
    endtask

    task automatic sess_begin;
        SCLK_IN = 1'b0;
        RST_IN  = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic sess_end;
        SCLK_IN = 1'b0;
        wait_cyc(HALF);
        RST_IN = 1'b0;
        wait_cyc(8);
    endtask

    task automatic do_cmd(input logic [7:0] op);
        sess_begin();
        send_bits({1'b0, op}, 8);
        sess_end();
    endtask

    task automatic do_write(input logic [7:0] op, input logic [8:0] v, input int n);
        sess_begin();
        send_bits({1'b0, op}, 8);
        send_bits(v, n);
        sess_end();
    endtask

    task automatic do_read(input string tag, input logic [7:0] op, input int n, input logic [8:0] exp);
        logic [8:0] v;
        int         miss;
        sess_begin();
        send_bits({1'b0, op}, 8);
        check({tag, "_oe_pre"}, DQ_OE, 1'b0);
        read_bits(n, v, miss);
        check({tag, "_data"}, v, exp);
        check({tag, "_oe_miss"}, miss, 0);
        check({tag, "_oe_post"}, DQ_OE, 1'b0);
        sess_end();
    endtask

    initial begin
        logic [8:0] v;
        int         miss;
        int         c0;

        CLR = 1'b1;
        wait_cyc(3);
        CLR = 1'b0;
        wait_cyc(2);

        // reset state: TEMP=0 vs TH=0x050, TL=0x028
        check("rst_dq_oe", DQ_OE, 1'b0);
        check("rst_dq_out", DQ_OUT, 1'b0);
        check("rst_temp", TEMP, 9'h000);
        check("rst_active", CONV_ACTIVE, 1'b0);
        check("rst_thigh", THIGH, 1'b0);
        check("rst_tlow", TLOW, 1'b1);

        // continuous conversion of +25.0 C
        TEMP_IN = 9'h032;
        do_cmd(8'hEE);
        check("ee_active", CONV_ACTIVE, 1'b1);
        wait_cyc(CONV + 5);
        check("conv_temp", TEMP, 9'h032);
        do_cmd(8'h22);
        check("stop_active", CONV_ACTIVE, 1'b0);
        check("conv_thigh", THIGH, 1'b0);
        check("conv_tlow", TLOW, 1'b0);

        // AA read; DQ_OE must be high from first fall (+sync) to last rise (+sync)
        c0 = oe_cnt;
        do_read("rd_temp", 8'hAA, 9, 9'h032);
        check("rd_temp_oe_cycles", oe_cnt - c0, 2 * HALF * 9 - HALF);

        // TH write of -5.0 C and read-back
        do_write(8'h01, 9'h1F6, 9);
        do_read("rd_th", 8'hA1, 9, 9'h1F6);
        check("th_neg_thigh", THIGH, 1'b1);
        check("th_neg_tlow", TLOW, 1'b0);

        // aborted TL write: only 5 data bits, then RST_IN low
        sess_begin();
        send_bits(9'h000 | 8'h02, 8);
        send_bits(9'h1FF, 5);
        RST_IN = 1'b0;
        wait_cyc(3);
        check("abort_oe", DQ_OE, 1'b0);
        SCLK_IN = 1'b0;
        wait_cyc(8);
        do_read("rd_tl_abort", 8'hA2, 9, 9'h028);

        // one-shot conversion with TH restored to +40.0 C
        do_write(8'h01, 9'h050, 9);
        do_write(8'h0C, 9'h001, 8);
        c0 = act_cnt;
        do_cmd(8'hEE);
        wait_cyc(CONV + 20);
        check("oneshot_cycles", act_cnt - c0, CONV);
        check("oneshot_active", CONV_ACTIVE, 1'b0);
        do_read("rd_cfg1", 8'hAC, 8, 9'h089);

        // one-shot at -4.0 C sets TLF only
        TEMP_IN = 9'h1F8;
        do_cmd(8'hEE);
        wait_cyc(CONV + 20);
        check("oneshot2_temp", TEMP, 9'h1F8);
        check("oneshot2_tlow", TLOW, 1'b1);
        check("oneshot2_thigh", THIGH, 1'b0);
        do_read("rd_cfg2", 8'hAC, 8, 9'h0A9);

        // CFG write with bit5=0 clears TLF, DONE and 1SHOT remain
        do_write(8'h0C, 9'h001, 8);
        do_read("rd_cfg3", 8'hAC, 8, 9'h089);

        // unknown opcode: responder never drives DQ
        c0 = oe_cnt;
        sess_begin();
        send_bits(9'h055, 8);
        read_bits(9, v, miss);
        sess_end();
        check("unk_oe_cycles", oe_cnt - c0, 0);

        // CLR during the 4th bit of an AA read, with TH moved away from its init
        do_write(8'h01, 9'h1F0, 9);
        check("pre_clr_thigh", THIGH, 1'b1);
        sess_begin();
        send_bits(9'h0AA, 8);
        read_bits(3, v, miss);
        SCLK_IN = 1'b0;
        wait_cyc(HALF - 1);
        check("pre_clr_oe", DQ_OE, 1'b1);
        CLR = 1'b1;
        wait_cyc(1);
        CLR = 1'b0;
        check("clr_oe", DQ_OE, 1'b0);
        check("clr_temp", TEMP, 9'h000);
        check("clr_thigh", THIGH, 1'b0);
        check("clr_tlow", TLOW, 1'b1);
        RST_IN = 1'b0;
        wait_cyc(8);
        do_read("rd_th_clr", 8'hA1, 9, 9'h050);
        do_read("rd_tl_clr", 8'hA2, 9, 9'h028);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
